// File: rtl/uart_tx_serial_8n1_if.sv
// Handshake bundle between the send-data control unit (master) and the
// 8N1 UART transmitter (slave).
interface uart_tx_serial_8n1_if;
  logic       iniciar_transmissao;
  logic [7:0] dados;
  logic       saida_serial;
  logic       ocupado;
  logic       acabou_transmissao;
  logic [3:0] db_estado;

  modport master (
    output iniciar_transmissao,
    output dados,
    input  saida_serial,
    input  ocupado,
    input  acabou_transmissao,
    input  db_estado
  );

  modport slave (
    input  iniciar_transmissao,
    input  dados,
    output saida_serial,
    output ocupado,
    output acabou_transmissao,
    output db_estado
  );
endinterface

// File: rtl/uart_tx_serial_8n1.sv
// Serial UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. All outputs come straight from flops.
module uart_tx_serial_8n1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic                 clock,
  input logic                 reset,
  uart_tx_serial_8n1_if.slave bus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  localparam logic [2:0] REPOUSO  = 3'd0;
  localparam logic [2:0] INICIO   = 3'd1;
  localparam logic [2:0] DADOS    = 3'd2;
  localparam logic [2:0] PARIDADE = 3'd3;
  localparam logic [2:0] PARADA   = 3'd4;
  localparam logic [2:0] FINAL    = 3'd5;

  logic [2:0]    r_state;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_saida;
  logic          r_ocupado;
  logic          r_acabou;

  logic w_bitEnd;
  logic w_parityIn;

  assign w_bitEnd   = (r_tick == TICK_LAST);
  assign w_parityIn = (PARITY == 2) ? ~^bus.dados : ^bus.dados;

  // Output registers are loaded with the value of the state being entered,
  // so the line changes on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= REPOUSO;
      r_tick    <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_saida   <= 1'b1;
      r_ocupado <= 1'b0;
      r_acabou  <= 1'b0;
    end else begin
      case (r_state)
        REPOUSO: begin
          if (bus.iniciar_transmissao) begin
            r_shift   <= bus.dados;
            r_parity  <= w_parityIn;
            r_state   <= INICIO;
            r_saida   <= 1'b0;
            r_ocupado <= 1'b1;
            r_tick    <= '0;
            r_bitIdx  <= '0;
          end
        end
        INICIO: begin
          if (w_bitEnd) begin
            r_tick  <= '0;
            r_state <= DADOS;
            r_saida <= r_shift[0];
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        DADOS: begin
          if (w_bitEnd) begin
            r_tick   <= '0;
            r_shift  <= {1'b0, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
            if (r_bitIdx == 3'd7) begin
              if (PARITY != 0) begin
                r_state <= PARIDADE;
                r_saida <= r_parity;
              end else begin
                r_state <= PARADA;
                r_saida <= 1'b1;
              end
            end else begin
              r_saida <= r_shift[1];
            end
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        PARIDADE: begin
          if (w_bitEnd) begin
            r_tick  <= '0;
            r_state <= PARADA;
            r_saida <= 1'b1;
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        // The bit index wrapped to zero after data bit 7 and now counts stop bits.
        PARADA: begin
          if (w_bitEnd) begin
            r_tick <= '0;
            if (r_bitIdx == LAST_STOP) begin
              r_state   <= FINAL;
              r_ocupado <= 1'b0;
              r_acabou  <= 1'b1;
              r_bitIdx  <= '0;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_tick <= r_tick + TICK_ONE;
          end
        end
        FINAL: begin
          r_state  <= REPOUSO;
          r_acabou <= 1'b0;
        end
        default: begin
          r_state   <= REPOUSO;
          r_tick    <= '0;
          r_bitIdx  <= '0;
          r_saida   <= 1'b1;
          r_ocupado <= 1'b0;
          r_acabou  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.saida_serial       = r_saida;
  assign bus.ocupado            = r_ocupado;
  assign bus.acabou_transmissao = r_acabou;
  assign bus.db_estado          = {1'b0, r_state};

endmodule

// File: tb/tb_uart_tx_serial_8n1.sv
// Directed bench: four transmitters (no parity, even, odd, two stop bits)
// share the same start/data stimulus and are checked cycle by cycle.
module tb_uart_tx_serial_8n1;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tbStart = 1'b0;
  logic [7:0] tbData = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  int parCfg[4]  = '{0, 1, 2, 0};
  int stopCfg[4] = '{1, 1, 1, 2};

  logic [3:0] txLine;
  logic [3:0] busy;
  logic [3:0] doneP;
  logic [3:0] dbState [4];

  always #5 clock = ~clock;

  uart_tx_serial_8n1_if bus0 ();
  uart_tx_serial_8n1_if bus1 ();
  uart_tx_serial_8n1_if bus2 ();
  uart_tx_serial_8n1_if bus3 ();

  assign bus0.iniciar_transmissao = tbStart;
  assign bus1.iniciar_transmissao = tbStart;
  assign bus2.iniciar_transmissao = tbStart;
  assign bus3.iniciar_transmissao = tbStart;
  assign bus0.dados = tbData;
  assign bus1.dados = tbData;
  assign bus2.dados = tbData;
  assign bus3.dados = tbData;

  assign txLine = {bus3.saida_serial, bus2.saida_serial, bus1.saida_serial, bus0.saida_serial};
  assign busy   = {bus3.ocupado, bus2.ocupado, bus1.ocupado, bus0.ocupado};
  assign doneP  = {bus3.acabou_transmissao, bus2.acabou_transmissao,
                   bus1.acabou_transmissao, bus0.acabou_transmissao};
  assign dbState[0] = bus0.db_estado;
  assign dbState[1] = bus1.db_estado;
  assign dbState[2] = bus2.db_estado;
  assign dbState[3] = bus3.db_estado;

  uart_tx_serial_8n1 #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave));
  uart_tx_serial_8n1 #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave));
  uart_tx_serial_8n1 #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2.slave));
  uart_tx_serial_8n1 #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clock(clock), .reset(reset), .bus(bus3.slave));

  // Expected {db_estado, done, busy, line} for cycle c after a start at cycle 0.
  function automatic logic [6:0] modelAt(int par, int stops, int c, logic [7:0] data);
    int n;
    int slot;
    logic line;
    logic [3:0] st;
    n = (9 + ((par != 0) ? 1 : 0) + stops) * CPB;
    if (c >= 1 && c <= n) begin
      slot = (c - 1) / CPB;
      if (slot == 0) begin
        line = 1'b0; st = 4'd1;
      end else if (slot <= 8) begin
        line = data[slot-1]; st = 4'd2;
      end else if (par != 0 && slot == 9) begin
        line = (par == 1) ? ^data : ~^data; st = 4'd3;
      end else begin
        line = 1'b1; st = 4'd4;
      end
      return {st, 1'b0, 1'b1, line};
    end else if (c == n + 1) begin
      return {4'd5, 1'b1, 1'b0, 1'b1};
    end
    return {4'd0, 1'b0, 1'b0, 1'b1};
  endfunction

  // Every comparison goes through here and bumps the counters.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkDut(input int k, input int c, input logic [7:0] data);
    logic [6:0] e;
    e = modelAt(parCfg[k], stopCfg[k], c, data);
    checkOutput($sformatf("d%0d c%0d line", k, c), {7'd0, txLine[k]}, {7'd0, e[0]});
    checkOutput($sformatf("d%0d c%0d busy", k, c), {7'd0, busy[k]},   {7'd0, e[1]});
    checkOutput($sformatf("d%0d c%0d done", k, c), {7'd0, doneP[k]},  {7'd0, e[2]});
    checkOutput($sformatf("d%0d c%0d state", k, c), {4'd0, dbState[k]}, {4'd0, e[6:3]});
  endtask

  task automatic checkIdle(input string tag);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s d%0d line", tag, k), {7'd0, txLine[k]}, 8'd1);
      checkOutput($sformatf("%s d%0d busy", tag, k), {7'd0, busy[k]}, 8'd0);
      checkOutput($sformatf("%s d%0d done", tag, k), {7'd0, doneP[k]}, 8'd0);
      checkOutput($sformatf("%s d%0d state", tag, k), {4'd0, dbState[k]}, 8'd0);
    end
  endtask

  // Called at a negedge: drives inputs that the next rising edge will sample.
  task automatic applyStimulus(input logic start, input logic [7:0] data);
    tbStart = start;
    tbData  = data;
  endtask

  // Starts a frame now and checks all DUTs for 46 cycles; optional extra
  // start pulses at pulseA/pulseB carry 0xFF and must be ignored.
  task automatic runFrame(input logic [7:0] data, input int pulseA, input int pulseB);
    int doneCount;
    doneCount = 0;
    applyStimulus(1'b1, data);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clock);
      for (int k = 0; k < 4; k++) checkDut(k, c, data);
      if (doneP[0]) doneCount++;
      if (c == pulseA || c == pulseB) applyStimulus(1'b1, 8'hFF);
      else applyStimulus(1'b0, data);
    end
    checkOutput($sformatf("done count %0h", data), 8'(doneCount), 8'd1);
  endtask

  initial begin
    logic [7:0] bytes [3];
    logic [7:0] rx;
    int fallCycle;
    int totalDone;
    logic doneSeen;
    bytes = '{8'h01, 8'h80, 8'hFF};

    repeat (3) @(negedge clock);
    checkIdle("reset");
    reset = 1'b0;
    @(negedge clock);

    runFrame(8'h55, -1, -1);
    runFrame(8'hA3, 10, 41);
    runFrame(8'h07, -1, -1);

    // Hand-computed parity slot for 0x07 (three ones): even -> 1, odd -> 0.
    applyStimulus(1'b1, 8'h07);
    repeat (38) @(negedge clock);
    applyStimulus(1'b0, 8'h07);
    checkOutput("even parity 07", {7'd0, txLine[1]}, 8'd1);
    checkOutput("odd parity 07", {7'd0, txLine[2]}, 8'd0);
    repeat (7) @(negedge clock);
    checkOutput("done at 45 odd", {7'd0, doneP[2]}, 8'd1);
    checkOutput("done at 45 stop2", {7'd0, doneP[3]}, 8'd1);
    @(negedge clock);

    runFrame(8'h00, -1, -1);

    // Reset in the middle of a 0x0F frame.
    applyStimulus(1'b1, 8'h0F);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      for (int k = 0; k < 4; k++) checkDut(k, c, 8'h0F);
      applyStimulus(1'b0, 8'h0F);
      if (c == 20) reset = 1'b1;
    end
    @(negedge clock);
    checkIdle("abort c21");
    reset = 1'b0;
    @(negedge clock);
    checkIdle("abort c22");
    @(negedge clock);
    runFrame(8'h0F, -1, -1);

    // Control unit emulation on dut0 with a mid-bit sampling receiver.
    totalDone = 0;
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b1, bytes[b]);
      fallCycle = -1;
      rx = 8'h00;
      doneSeen = 1'b0;
      for (int c = 1; c <= 60 && !doneSeen; c++) begin
        @(negedge clock);
        applyStimulus(1'b0, bytes[b]);
        if (fallCycle < 0 && txLine[0] == 1'b0) fallCycle = c;
        if (fallCycle >= 0) begin
          if (c - fallCycle == 1)
            checkOutput($sformatf("rx%0d start", b), {7'd0, txLine[0]}, 8'd0);
          for (int i = 0; i < 8; i++)
            if (c - fallCycle == 1 + CPB * (i + 1)) rx[i] = txLine[0];
          if (c - fallCycle == 1 + CPB * 9)
            checkOutput($sformatf("rx%0d stop", b), {7'd0, txLine[0]}, 8'd1);
        end
        if (doneP[0]) begin
          doneSeen = 1'b1;
          totalDone++;
        end
      end
      checkOutput($sformatf("rx%0d done seen", b), {7'd0, doneSeen}, 8'd1);
      checkOutput($sformatf("rx%0d byte", b), rx, bytes[b]);
      repeat (2) @(negedge clock);
    end
    checkOutput("three done pulses", 8'(totalDone), 8'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
